// File: rtl/intdiv_iter_pkg.sv
// intdiv_iter_pkg: shared configuration struct, divider FSM states and cycle-count helper.
package intdiv_iter_pkg;
  typedef struct packed {
    int   XLEN;
    int   IDIV_BITSPERCYCLE;
    logic M_SUPPORTED;
    logic IDIV_ON_FPU;
  } cvw_t;
  localparam cvw_t CVW_DEFAULT = '{XLEN: 64, IDIV_BITSPERCYCLE: 2, M_SUPPORTED: 1'b1, IDIV_ON_FPU: 1'b0};
  typedef enum logic [1:0] {IDLE, BUSY, DONE} intdiv_state_t;
  function automatic int idiv_cycles(int xlen, int bpc, logic w64);
    return (w64 && xlen == 64) ? 32 / bpc : xlen / bpc;
  endfunction
endpackage

// File: rtl/intdiv_iter_if.sv
// intdiv_iter_if: start/busy/done handshake and operand/result bus of the divider.
interface intdiv_iter_if #(parameter int XLEN = 64);
  logic            Start, FlushE, Signed, RemOp, W64, Busy, Done;
  logic [XLEN-1:0] A, B, Result;
  modport master (output Start, FlushE, Signed, RemOp, W64, A, B, input Busy, Done, Result);
  modport slave  (input Start, FlushE, Signed, RemOp, W64, A, B, output Busy, Done, Result);
endinterface

// File: rtl/intdiv_iter_step.sv
// intdiv_iter_step: BPC chained restoring-subtract stages, quotient bits shifted in at the LSB.
module intdiv_iter_step #(
  parameter int XLEN = 64,
  parameter int BPC  = 2
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] div,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);
  logic [XLEN:0]   r [BPC+1];
  logic [XLEN-1:0] q [BPC+1];
  assign r[0] = rem;
  assign q[0] = quo;
  for (genvar i = 0; i < BPC; i++) begin : g_stage
    logic [XLEN+1:0] sh, diff;
    logic            ge;
    assign sh      = {r[i], q[i][XLEN-1]};
    assign diff    = sh - {2'b00, div};
    assign ge      = !diff[XLEN+1];
    assign r[i+1]  = ge ? diff[XLEN:0] : sh[XLEN:0];
    assign q[i+1]  = {q[i][XLEN-2:0], ge};
  end
  assign rem_next = r[BPC];
  assign quo_next = q[BPC];
endmodule

// File: rtl/intdiv_iter.sv
// intdiv_iter: multi-cycle restoring divider/remainder unit (DIV/DIVU/REM/REMU and W forms).
module intdiv_iter
  import intdiv_iter_pkg::*;
#(
  parameter cvw_t P = CVW_DEFAULT
) (
  input logic          clk,
  input logic          reset,
  intdiv_iter_if.slave bus
);
  localparam int XLEN = P.XLEN;
  localparam int BPC  = P.IDIV_BITSPERCYCLE;
  localparam int N    = XLEN / BPC;
  localparam int CW   = $clog2(N + 1);
  intdiv_state_t   state;
  logic            busy, done, rem_op, w_op, neg_q, neg_r;
  logic            w, a_neg, b_neg, b_zero, ovf;
  logic [XLEN-1:0] result, quo, div, quo_next, a_ext, b_ext, a_mag, b_mag;
  logic [XLEN:0]   rem, rem_next;
  logic [CW-1:0]   cnt;
  function automatic logic [XLEN-1:0] fix(logic [XLEN-1:0] q, logic [XLEN-1:0] r, logic nq, logic nr,
                                          logic ro, logic wo);
    logic [XLEN-1:0] v;
    v = ro ? (nr ? -r : r) : (nq ? -q : q);
    return wo ? XLEN'($signed(v[31:0])) : v;
  endfunction
  assign w      = bus.W64 && XLEN == 64;
  assign a_ext  = w ? (bus.Signed ? XLEN'($signed(bus.A[31:0])) : XLEN'(bus.A[31:0])) : bus.A;
  assign b_ext  = w ? (bus.Signed ? XLEN'($signed(bus.B[31:0])) : XLEN'(bus.B[31:0])) : bus.B;
  assign a_neg  = bus.Signed && a_ext[XLEN-1];
  assign b_neg  = bus.Signed && b_ext[XLEN-1];
  assign a_mag  = a_neg ? -a_ext : a_ext;
  assign b_mag  = b_neg ? -b_ext : b_ext;
  assign b_zero = b_ext == '0;
  assign ovf    = bus.Signed && b_ext == '1 &&
                  (w ? bus.A[31:0] == 32'h8000_0000 : a_ext == {1'b1, {(XLEN-1){1'b0}}});
  intdiv_iter_step #(.XLEN(XLEN), .BPC(BPC)) u_step (
    .rem(rem), .quo(quo), .div(div), .rem_next(rem_next), .quo_next(quo_next)
  );
  // Result is loaded on the edge entering DONE so it is valid during the Done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      quo    <= '0;
      rem    <= '0;
      div    <= '0;
      cnt    <= '0;
      rem_op <= 1'b0;
      w_op   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (bus.FlushE) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.Start) begin
          rem_op <= bus.RemOp;
          w_op   <= w;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          div    <= b_mag;
          quo    <= w ? a_mag << (XLEN - 32) : a_mag;
          rem    <= '0;
          cnt    <= CW'(idiv_cycles(XLEN, BPC, w));
          if (b_zero || ovf) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= fix(b_zero ? '1 : a_ext, b_zero ? a_ext : '0, 1'b0, 1'b0, bus.RemOp, w);
          end else begin
            state <= BUSY;
            busy  <= 1'b1;
          end
        end
        BUSY: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= fix(quo_next, rem_next[XLEN-1:0], neg_q, neg_r, rem_op, w_op);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.Busy   = busy;
  assign bus.Done   = done;
  assign bus.Result = result;
endmodule

// File: tb/tb_intdiv_iter.sv
// tb_intdiv_iter: directed checks of latency, results, special cases, flush and reset.
module tb_intdiv_iter;
  import intdiv_iter_pkg::*;
  localparam cvw_t CFG = '{XLEN: 64, IDIV_BITSPERCYCLE: 2, M_SUPPORTED: 1'b1, IDIV_ON_FPU: 1'b0};
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  intdiv_iter_if #(.XLEN(64)) bus ();
  intdiv_iter #(.P(CFG)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic run_op(input logic s, input logic ro, input logic w, input logic [63:0] a,
                        input logic [63:0] b, output int lat, output int nbusy, output logic [63:0] res);
    @(negedge clk);
    bus.Signed = s; bus.RemOp = ro; bus.W64 = w; bus.A = a; bus.B = b; bus.Start = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    lat = -1; nbusy = 0; res = 'x;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.Busy) nbusy++;
      if (bus.Done) begin
        lat = k; res = bus.Result;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bus.Start = 0; bus.FlushE = 0; bus.Signed = 0; bus.RemOp = 0; bus.W64 = 0; bus.A = 0; bus.B = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.Busy, bus.Done} !== 2'b00 || bus.Result !== 64'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h want 0 0 0", bus.Busy, bus.Done, bus.Result);
    end
  endtask

  task automatic test_unsigned;
    int lat, nb; logic [63:0] r;
    run_op(0, 0, 0, 64'd100, 64'd7, lat, nb, r);
    checks++;
    if (lat !== 33 || nb !== 32) begin
      errors++; $display("FAIL divu_timing: done_at=%0d busy=%0d want 33 32", lat, nb);
    end
    checks++;
    if (r !== 64'd14) begin errors++; $display("FAIL divu: got %h want %h", r, 64'd14); end
    @(negedge clk);
    checks++;
    if (bus.Done !== 1'b0 || bus.Result !== 64'd14) begin
      errors++; $display("FAIL divu_hold: done=%b result=%h want 0 %h", bus.Done, bus.Result, 64'd14);
    end
    run_op(0, 1, 0, 64'd100, 64'd7, lat, nb, r);
    checks++;
    if (r !== 64'd2) begin errors++; $display("FAIL remu: got %h want %h", r, 64'd2); end
  endtask

  task automatic test_signed;
    int lat, nb; logic [63:0] r;
    run_op(1, 0, 0, -64'sd7, 64'd2, lat, nb, r);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_neg_a: got %h want fffffffffffffffd", r); end
    run_op(1, 1, 0, -64'sd7, 64'd2, lat, nb, r);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rem_neg_a: got %h want ffffffffffffffff", r); end
    run_op(1, 0, 0, 64'd7, -64'sd2, lat, nb, r);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_neg_b: got %h want fffffffffffffffd", r); end
  endtask

  task automatic test_special;
    int lat, nb; logic [63:0] r;
    run_op(1, 0, 0, 64'd5, 64'd0, lat, nb, r);
    checks++;
    if (lat !== 1 || nb !== 0) begin errors++; $display("FAIL divz_timing: done_at=%0d busy=%0d want 1 0", lat, nb); end
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL divz: got %h want ffffffffffffffff", r); end
    run_op(1, 1, 0, 64'd5, 64'd0, lat, nb, r);
    checks++;
    if (r !== 64'd5) begin errors++; $display("FAIL remz: got %h want 5", r); end
    run_op(1, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, nb, r);
    checks++;
    if (r !== 64'h8000_0000_0000_0000 || lat !== 1) begin
      errors++; $display("FAIL div_ovf: got %h at %0d want 8000000000000000 at 1", r, lat);
    end
    run_op(1, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, nb, r);
    checks++;
    if (r !== 64'd0) begin errors++; $display("FAIL rem_ovf: got %h want 0", r); end
  endtask

  task automatic test_word;
    int lat, nb; logic [63:0] r;
    run_op(0, 0, 1, 64'hFFFF_FFFF_8000_0000, 64'd1, lat, nb, r);
    checks++;
    if (lat !== 17 || nb !== 16) begin errors++; $display("FAIL divuw_timing: done_at=%0d busy=%0d want 17 16", lat, nb); end
    checks++;
    if (r !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL divuw: got %h want ffffffff80000000", r); end
    run_op(1, 0, 1, 64'h1_0000_0007, 64'd2, lat, nb, r);
    checks++;
    if (r !== 64'd3) begin errors++; $display("FAIL divw: got %h want 3", r); end
  endtask

  task automatic test_flush;
    int lat, nb; logic [63:0] r, prev;
    prev = bus.Result;
    @(negedge clk);
    bus.Signed = 0; bus.RemOp = 0; bus.W64 = 0; bus.A = 64'd100; bus.B = 64'd7; bus.Start = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (bus.Busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %b want 1", bus.Busy); end
    bus.FlushE = 1'b1;
    @(posedge clk);
    #1 bus.FlushE = 1'b0;
    checks++;
    if ({bus.Busy, bus.Done} !== 2'b00 || bus.Result !== prev) begin
      errors++; $display("FAIL flush: busy=%b done=%b result=%h want 0 0 %h", bus.Busy, bus.Done, bus.Result, prev);
    end
    run_op(0, 1, 0, 64'd100, 64'd7, lat, nb, r);
    checks++;
    if (lat !== 33 || r !== 64'd2) begin errors++; $display("FAIL after_flush: done_at=%0d result=%h want 33 2", lat, r); end
  endtask

  task automatic test_back_to_back;
    int lat, nb; logic [63:0] r;
    @(negedge clk);
    bus.Signed = 0; bus.RemOp = 0; bus.W64 = 0; bus.A = 64'd100; bus.B = 64'd7; bus.Start = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    lat = -1; r = 'x;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 5) begin
        bus.A = 64'd9; bus.B = 64'd3; bus.Signed = 1; bus.RemOp = 1; bus.Start = 1'b1;
      end else bus.Start = 1'b0;
      if (bus.Done) begin
        lat = k; r = bus.Result;
        bus.A = 64'd50; bus.B = 64'd5; bus.Signed = 0; bus.RemOp = 0; bus.Start = 1'b1;
        break;
      end
    end
    checks++;
    if (lat !== 33 || r !== 64'd14) begin errors++; $display("FAIL start_in_busy: done_at=%0d result=%h want 33 e", lat, r); end
    @(negedge clk);
    bus.Start = 1'b0;
    checks++;
    if ({bus.Busy, bus.Done} !== 2'b00) begin
      errors++; $display("FAIL start_in_done: busy=%b done=%b want 0 0", bus.Busy, bus.Done);
    end
    run_op(0, 0, 0, 64'd50, 64'd5, lat, nb, r);
    checks++;
    if (lat !== 33 || r !== 64'd10) begin errors++; $display("FAIL back_to_back: done_at=%0d result=%h want 33 a", lat, r); end
  endtask

  task automatic test_reset_mid;
    int lat, nb; logic [63:0] r;
    @(negedge clk);
    bus.Signed = 0; bus.RemOp = 0; bus.W64 = 0; bus.A = 64'd100; bus.B = 64'd7; bus.Start = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if ({bus.Busy, bus.Done} !== 2'b00 || bus.Result !== 64'd0) begin
      errors++; $display("FAIL reset_mid: busy=%b done=%b result=%h want 0 0 0", bus.Busy, bus.Done, bus.Result);
    end
    run_op(0, 0, 0, 64'd100, 64'd7, lat, nb, r);
    checks++;
    if (lat !== 33 || nb !== 32 || r !== 64'd14) begin
      errors++; $display("FAIL after_reset: done_at=%0d busy=%0d result=%h want 33 32 e", lat, nb, r);
    end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_special;
    test_word;
    test_flush;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
